// File: rtl/eth_prbs_checker.sv
// Self-synchronising PRBS7/9/15/23/31 checker for the 10G RX path: predicts each bit from
// previously received bits, tracks lock and accumulates a saturating error-bit count.
module eth_prbs_checker #(
    parameter int DATA_WIDTH       = 64,
    parameter int ERR_CNT_WIDTH    = 16,
    parameter int LOCK_GOOD_WORDS  = 4,
    parameter int UNLOCK_BAD_WORDS = 16,
    parameter bit BIT_REVERSE      = 1'b0
) (
    input  logic                             rx_clk,
    input  logic                             rx_rst_n,
    input  logic                             cfg_enable,
    input  logic [2:0]                       cfg_mode,
    input  logic                             cfg_invert,
    input  logic [DATA_WIDTH-1:0]            in_data,
    input  logic                             in_valid,
    input  logic                             err_clear,
    output logic                             locked,
    output logic                             err_block,
    output logic [$clog2(DATA_WIDTH+1)-1:0]  err_bits,
    output logic [ERR_CNT_WIDTH-1:0]         err_count
);
    localparam int EBW = $clog2(DATA_WIDTH + 1);
    localparam int GW  = $clog2(LOCK_GOOD_WORDS + 1);
    localparam int BW  = $clog2(UNLOCK_BAD_WORDS + 1);
    localparam int SW  = ((ERR_CNT_WIDTH > EBW) ? ERR_CNT_WIDTH : EBW) + 1;

    typedef enum logic {HUNT, LOCK} state_t;

    state_t                   state;
    logic [30:0]              hist;      // hist[k-1] is the bit k positions back in time
    logic [30:0]              hist_nxt;
    logic [2:0]               mode_q;
    logic [GW-1:0]            good_cnt;
    logic [BW-1:0]            bad_cnt;
    logic [4:0]               tap_a, tap_b;
    logic [DATA_WIDTH-1:0]    err_vec;
    logic [EBW-1:0]           nbits;
    logic                     word_err;
    logic                     force_hunt;
    logic [SW-1:0]            sum;
    logic [ERR_CNT_WIDTH-1:0] sat_sum;

    always_comb begin
        case (cfg_mode)
            3'd0:    begin tap_a = 5'd6;  tap_b = 5'd5;  end
            3'd1:    begin tap_a = 5'd8;  tap_b = 5'd4;  end
            3'd2:    begin tap_a = 5'd14; tap_b = 5'd13; end
            3'd3:    begin tap_a = 5'd22; tap_b = 5'd17; end
            default: begin tap_a = 5'd30; tap_b = 5'd27; end
        endcase
    end

    // Walk the word bit by bit in time order; history takes the raw received bit.
    always_comb begin
        logic        b;
        logic [30:0] h;
        h       = hist;
        b       = 1'b0;
        err_vec = '0;
        nbits   = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            b          = BIT_REVERSE ? in_data[DATA_WIDTH-1-i] : in_data[i];
            err_vec[i] = b ^ h[tap_a] ^ h[tap_b] ^ cfg_invert;
            h          = {h[29:0], b};
        end
        hist_nxt = h;
        for (int i = 0; i < DATA_WIDTH; i++)
            nbits = nbits + EBW'(err_vec[i]);
    end

    assign word_err   = (nbits != '0);
    assign force_hunt = !cfg_enable || (cfg_mode != mode_q) || (cfg_mode > 3'd4);
    assign sum        = SW'(err_count) + SW'(nbits);
    assign sat_sum    = (sum > SW'({ERR_CNT_WIDTH{1'b1}})) ? {ERR_CNT_WIDTH{1'b1}}
                                                           : sum[ERR_CNT_WIDTH-1:0];

    always_ff @(posedge rx_clk) begin
        if (!rx_rst_n) begin
            state     <= HUNT;
            hist      <= '0;
            mode_q    <= '0;
            good_cnt  <= '0;
            bad_cnt   <= '0;
            locked    <= 1'b0;
            err_block <= 1'b0;
            err_bits  <= '0;
            err_count <= '0;
        end else begin
            mode_q    <= cfg_mode;
            if (in_valid)
                hist <= hist_nxt;
            err_bits  <= (in_valid && cfg_enable) ? nbits : '0;
            err_block <= in_valid && cfg_enable && word_err;

            // Only words checked while already locked contribute; clear wins.
            if (err_clear)
                err_count <= '0;
            else if (in_valid && cfg_enable && state == LOCK)
                err_count <= sat_sum;

            if (force_hunt) begin
                state    <= HUNT;
                locked   <= 1'b0;
                good_cnt <= '0;
                bad_cnt  <= '0;
            end else if (in_valid) begin
                case (state)
                    HUNT: begin
                        if (word_err)
                            good_cnt <= '0;
                        else if (good_cnt == GW'(LOCK_GOOD_WORDS - 1)) begin
                            state    <= LOCK;
                            locked   <= 1'b1;
                            good_cnt <= '0;
                            bad_cnt  <= '0;
                        end else
                            good_cnt <= good_cnt + 1'b1;
                    end
                    LOCK: begin
                        if (!word_err)
                            bad_cnt <= '0;
                        else if (bad_cnt == BW'(UNLOCK_BAD_WORDS - 1)) begin
                            state    <= HUNT;
                            locked   <= 1'b0;
                            good_cnt <= '0;
                            bad_cnt  <= '0;
                        end else
                            bad_cnt <= bad_cnt + 1'b1;
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_eth_prbs_checker.sv
// Bench for eth_prbs_checker: constant vector table, directed corner sequences and a
// randomized run against a bit-stream reference model.
module tb_eth_prbs_checker;
    localparam int DW  = 64;
    localparam int ECW = 4;
    localparam int EBW = $clog2(DW + 1);
    localparam int CMAX = (1 << ECW) - 1;

    logic           rx_clk = 1'b0;
    logic           rx_rst_n = 1'b0;
    logic           cfg_enable = 1'b1;
    logic [2:0]     cfg_mode = 3'd0;
    logic           cfg_invert = 1'b0;
    logic [DW-1:0]  in_data = '0;
    logic           in_valid = 1'b0;
    logic           err_clear = 1'b0;
    logic           locked, err_block;
    logic [EBW-1:0] err_bits;
    logic [ECW-1:0] err_count;

    int checks = 0;
    int errors = 0;

    always #5 rx_clk = ~rx_clk;

    eth_prbs_checker #(
        .DATA_WIDTH(DW), .ERR_CNT_WIDTH(ECW), .LOCK_GOOD_WORDS(4),
        .UNLOCK_BAD_WORDS(16), .BIT_REVERSE(1'b0)
    ) dut (
        .rx_clk(rx_clk), .rx_rst_n(rx_rst_n), .cfg_enable(cfg_enable), .cfg_mode(cfg_mode),
        .cfg_invert(cfg_invert), .in_data(in_data), .in_valid(in_valid), .err_clear(err_clear),
        .locked(locked), .err_block(err_block), .err_bits(err_bits), .err_count(err_count)
    );

    // Reference model state: received bits as a queue, newest at index 0.
    bit hq[$];
    int m_mode_q = 0;
    bit m_locked = 0;
    int m_good = 0, m_bad = 0, m_bits = 0, m_cnt = 0;
    bit m_skip = 0;
    bit gh[31];      // pattern generator history, newest at index 0

    function automatic int tap_a(input int mode);
        case (mode)
            0: return 7;  1: return 9;  2: return 15;  3: return 23;
            default: return 31;
        endcase
    endfunction

    function automatic int tap_b(input int mode);
        case (mode)
            0: return 6;  1: return 5;  2: return 14;  3: return 18;
            default: return 28;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int ta, tb, nb;
        bit b, pa, pb, was_locked, force_h;
        ta = tap_a(cfg_mode); tb = tap_b(cfg_mode); nb = 0;
        if (!rx_rst_n) begin
            hq.delete();
            m_mode_q = 0; m_locked = 0; m_good = 0; m_bad = 0; m_bits = 0; m_cnt = 0; m_skip = 0;
        end else begin
            if (in_valid) begin
                for (int i = 0; i < DW; i++) begin
                    b  = in_data[i];
                    pa = (hq.size() >= ta) ? hq[ta-1] : 1'b0;
                    pb = (hq.size() >= tb) ? hq[tb-1] : 1'b0;
                    nb += int'(b ^ pa ^ pb ^ cfg_invert);
                    hq.push_front(b);
                    if (hq.size() > 31) void'(hq.pop_back());
                end
            end
            was_locked = m_locked;
            force_h = !cfg_enable || (int'(cfg_mode) != m_mode_q) || (cfg_mode > 3'd4);
            m_mode_q = int'(cfg_mode);
            m_skip = (cfg_mode > 3'd4);
            m_bits = (in_valid && cfg_enable) ? nb : 0;
            if (err_clear) m_cnt = 0;
            else if (in_valid && cfg_enable && was_locked)
                m_cnt = (m_cnt + nb > CMAX) ? CMAX : m_cnt + nb;
            if (force_h) begin
                m_locked = 0; m_good = 0; m_bad = 0;
            end else if (in_valid) begin
                if (!m_locked) begin
                    m_good = (nb != 0) ? 0 : m_good + 1;
                    if (m_good == 4) begin m_locked = 1; m_good = 0; m_bad = 0; end
                end else begin
                    m_bad = (nb != 0) ? m_bad + 1 : 0;
                    if (m_bad == 16) begin m_locked = 0; m_good = 0; m_bad = 0; end
                end
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge rx_clk);
        #1;
        chk("model_locked", locked, int'(m_locked));
        if (!m_skip) begin
            chk("model_err_bits", err_bits, m_bits);
            chk("model_err_block", err_block, int'(m_bits != 0));
        end
        chk("model_err_count", err_count, m_cnt);
    endtask

    task automatic gen(output logic [DW-1:0] w);
        int ta, tb;
        bit nbit;
        ta = tap_a(cfg_mode); tb = tap_b(cfg_mode);
        for (int i = 0; i < DW; i++) begin
            nbit = gh[ta-1] ^ gh[tb-1];
            w[i] = nbit;
            for (int j = 30; j > 0; j--) gh[j] = gh[j-1];
            gh[0] = nbit;
        end
    endtask

    // kind: 0 pattern, 1 inverted pattern, 2 zeros, 3 random; flip < 0 means no flip
    task automatic send(input int kind, input int flip);
        logic [DW-1:0] w;
        gen(w);
        case (kind)
            1:       w = ~w;
            2:       w = '0;
            3:       w = {$urandom, $urandom};
            default: ;
        endcase
        if (flip >= 0) w[flip] = ~w[flip];
        in_data  = w;
        in_valid = 1'b1;
        tick();
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom};
        tick();
    endtask

    typedef struct {
        bit rst; bit inv; bit valid; bit clr; int kind;
        int e_lock; int e_bits; int e_cnt;   // -1 = not checked
    } vec_t;

    initial begin
        vec_t tbl[14];
        int r, kind;
        for (int i = 0; i < 31; i++) gh[i] = 1'b1;

        // PRBS7: inverted data without/with cfg_invert, gap, then zero words while locked
        tbl[0]  = '{1, 0, 0, 0, 0, 0,  0,  0};
        tbl[1]  = '{0, 0, 1, 0, 1, 0, -1,  0};
        tbl[2]  = '{0, 0, 1, 0, 1, 0, 64,  0};
        tbl[3]  = '{0, 0, 1, 0, 1, 0, 64,  0};
        tbl[4]  = '{0, 1, 1, 0, 1, 0,  0,  0};
        tbl[5]  = '{0, 1, 1, 0, 1, 0,  0,  0};
        tbl[6]  = '{0, 1, 1, 0, 1, 0,  0,  0};
        tbl[7]  = '{0, 1, 1, 0, 1, 1,  0,  0};
        tbl[8]  = '{0, 1, 0, 0, 1, 1,  0,  0};
        tbl[9]  = '{0, 1, 1, 0, 1, 1,  0,  0};
        tbl[10] = '{0, 1, 1, 0, 2, 1, -1, -1};
        tbl[11] = '{0, 1, 1, 0, 2, 1, 64, 15};
        tbl[12] = '{0, 1, 1, 1, 2, 1, 64,  0};
        tbl[13] = '{0, 1, 1, 0, 2, 1, 64, 15};

        cfg_mode = 3'd0;
        foreach (tbl[i]) begin
            rx_rst_n   = !tbl[i].rst;
            cfg_invert = tbl[i].inv;
            err_clear  = tbl[i].clr;
            if (tbl[i].valid) send(tbl[i].kind, -1);
            else idle();
            chk("tbl_locked", locked, tbl[i].e_lock);
            if (tbl[i].e_bits >= 0) begin
                chk("tbl_err_bits", err_bits, tbl[i].e_bits);
                chk("tbl_err_block", err_block, int'(tbl[i].e_bits != 0));
            end
            if (tbl[i].e_cnt >= 0) chk("tbl_err_count", err_count, tbl[i].e_cnt);
        end
        err_clear = 1'b0; cfg_invert = 1'b0;

        // PRBS31 clean stream from reset
        rx_rst_n = 1'b0; cfg_mode = 3'd4; idle();
        rx_rst_n = 1'b1; idle();
        for (int i = 0; i < 1000; i++) begin
            send(0, -1);
            if (i == 4) chk("prbs31_locked_by_word5", locked, 1);
        end
        chk("prbs31_count_clean", err_count, 0);
        chk("prbs31_still_locked", locked, 1);

        // Single flip near the word end spills two errors into the next word
        err_clear = 1'b1; send(0, -1); err_clear = 1'b0;
        send(0, 50);
        chk("flip50_bits", err_bits, 1);
        chk("flip50_count", err_count, 1);
        send(0, -1);
        chk("flip50_next_bits", err_bits, 2);
        chk("flip50_next_block", err_block, 1);
        chk("flip50_total", err_count, 3);
        send(0, -1);
        chk("flip50_quiet_block", err_block, 0);
        chk("flip50_locked", locked, 1);

        // Saturation: 3 errors per word
        err_clear = 1'b1; send(0, -1); err_clear = 1'b0;
        for (int i = 0; i < 6; i++) begin
            send(0, 0);
            chk("sat_bits", err_bits, 3);
            chk("sat_count", err_count, (3 * (i + 1) > 15) ? 15 : 3 * (i + 1));
        end
        err_clear = 1'b1; send(0, 0); err_clear = 1'b0;
        chk("clear_beats_add", err_count, 0);
        send(0, -1);

        // 15 bad + 1 clean keeps lock; 16 bad drops it
        for (int i = 0; i < 15; i++) send(0, 0);
        send(0, -1);
        chk("bad15_keeps_lock", locked, 1);
        for (int i = 0; i < 16; i++) begin
            send(0, 0);
            if (i == 14) chk("bad15_locked", locked, 1);
        end
        chk("bad16_unlocked", locked, 0);

        // Relock, gaps, mode switch, mid-run reset
        for (int i = 0; i < 4; i++) send(0, -1);
        chk("relock", locked, 1);
        for (int i = 0; i < 10; i++) begin idle(); send(0, -1); end
        chk("gaps_keep_lock", locked, 1);
        cfg_mode = 3'd0;
        send(0, -1);
        chk("mode_switch_unlock", locked, 0);
        for (int i = 0; i < 4; i++) begin idle(); send(0, -1); end
        chk("prbs7_relock", locked, 1);
        rx_rst_n = 1'b0; err_clear = 1'b1; send(0, 3);
        chk("rst_locked", locked, 0);
        chk("rst_bits", err_bits, 0);
        chk("rst_block", err_block, 0);
        chk("rst_count", err_count, 0);
        rx_rst_n = 1'b1; err_clear = 1'b0;

        // Reserved mode never locks
        idle(); cfg_mode = 3'd5;
        for (int i = 0; i < 8; i++) send(0, -1);
        chk("reserved_no_lock", locked, 0);
        cfg_mode = 3'd4;

        // Randomized run against the model
        for (int n = 0; n < 2000; n++) begin
            r = $urandom_range(0, 299);
            if (r == 0) cfg_mode = 3'($urandom_range(0, 5));
            if (r == 1) cfg_invert = ~cfg_invert;
            if (r == 2 || r == 3) cfg_enable = ~cfg_enable;
            rx_rst_n  = !(r == 4);
            err_clear = ($urandom_range(0, 29) == 0);
            kind = cfg_invert ? 1 : 0;
            r = $urandom_range(0, 39);
            if (r < 10) idle();
            else if (r < 14) send(kind, $urandom_range(0, DW - 1));
            else if (r == 14) send(3, -1);
            else send(kind, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
